// File: rtl/q_requant_fp32_to_int8_if.sv
// Port bundle for the FP32 -> INT8 requantizer: start/status plus both SRAM ports.
// Optional sat_cnt signal is present only when REQ_SAT_CNT_EN is defined.
interface q_requant_fp32_to_int8_if #(
    parameter int SRC_AW = 7,
    parameter int DST_AW = 5
);
    logic              en;
    logic              busy;
    logic              done;
    logic [127:0]      SRC_MEM_DOUT;
    logic              SRC_MEM_CEB;
    logic              SRC_MEM_WEN;
    logic [SRC_AW-1:0] SRC_MEM_ADDR;
    logic              DST_MEM_CEB;
    logic              DST_MEM_WEN;
    logic [DST_AW-1:0] DST_MEM_ADDR;
    logic [127:0]      DST_MEM_DIN;
`ifdef REQ_SAT_CNT_EN
    logic [15:0]       sat_cnt;
`endif

    // Requantizer side
    modport master (
        input  en, SRC_MEM_DOUT,
        output busy, done, SRC_MEM_CEB, SRC_MEM_WEN, SRC_MEM_ADDR,
               DST_MEM_CEB, DST_MEM_WEN, DST_MEM_ADDR, DST_MEM_DIN
`ifdef REQ_SAT_CNT_EN
        , output sat_cnt
`endif
    );

    // Controller / memory side
    modport slave (
        output en, SRC_MEM_DOUT,
        input  busy, done, SRC_MEM_CEB, SRC_MEM_WEN, SRC_MEM_ADDR,
               DST_MEM_CEB, DST_MEM_WEN, DST_MEM_ADDR, DST_MEM_DIN
`ifdef REQ_SAT_CNT_EN
        , input sat_cnt
`endif
    );
endinterface

// File: rtl/q_requant_fp32_to_int8.sv
// Reads FP32 Q words, requantizes to INT8 (x * 2^SCALE_EXP, round-half-away, saturate), packs 16 per word.
// Optional saturation counter enabled by defining REQ_SAT_CNT_EN.
module q_requant_fp32_to_int8 #(
    parameter int N_GROUPS  = 32,
    parameter int SCALE_EXP = 4,
    parameter int SRC_AW    = 7,
    parameter int DST_AW    = 5
) (
    input logic clk,
    input logic rst,
    q_requant_fp32_to_int8_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD, DRAIN, WR, DONE} state_t;

    state_t              state;
    logic [1:0]          k;
    logic [DST_AW-1:0]   grp;
    logic                cap_vld;
    logic [1:0]          cap_k;
    logic                src_ceb;
    logic [SRC_AW-1:0]   src_addr;
    logic                dst_ceb;
    logic                dst_wen;
    logic [DST_AW-1:0]   dst_addr;
    logic [127:0]        dst_din;
    logic [127:0]        pack;
    logic [127:0]        pack_next;
    logic                busy;
    logic                done;
    logic [3:0][7:0]     conv;
    logic                last_grp;

    // FP32 -> INT8 with power-of-two scale, round-half-away-from-zero, saturation
    function automatic logic [7:0] fp32_to_int8(input logic [31:0] x);
        logic               s;
        logic [7:0]         e;
        logic [22:0]        m;
        logic signed [9:0]  ee;
        logic [23:0]        mant;
        logic [4:0]         sh;
        logic [23:0]        shifted;
        logic               rbit;
        logic [8:0]         mag;
        logic [7:0]         sat_val;
        logic [7:0]         res;
        s       = x[31];
        e       = x[30:23];
        m       = x[22:0];
        ee      = $signed({2'b00, e}) - 10'sd127 + $signed(10'(SCALE_EXP));
        mant    = {1'b1, m};
        sh      = 5'(10'sd23 - ee);
        shifted = mant >> sh;
        rbit    = |(mant & (24'd1 << (sh - 5'd1)));
        mag     = 9'(shifted) + 9'(rbit);
        sat_val = s ? 8'h80 : 8'h7F;
        res     = 8'h00;
        if (e == 8'h00)
            res = 8'h00;
        else if (e == 8'hFF)
            res = (m == 23'd0) ? sat_val : 8'h00;
        else if (ee >= 10'sd7)
            res = sat_val;
        else if (ee < -10'sd1)
            res = 8'h00;
        else if (s)
            res = (mag >= 9'd128) ? 8'h80 : 8'(9'd0 - mag);
        else
            res = (mag >= 9'd127) ? 8'h7F : mag[7:0];
        return res;
    endfunction

    assign last_grp = (grp == DST_AW'(N_GROUPS - 1));

    // Convert the word returned by last cycle's read and merge it into the pack image
    always_comb begin
        pack_next = pack;
        for (int j = 0; j < 4; j++)
            conv[j] = fp32_to_int8(bus.SRC_MEM_DOUT[32*j +: 32]);
        if (cap_vld)
            pack_next[32*cap_k +: 32] = conv;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= 2'd0;
            grp      <= '0;
            cap_vld  <= 1'b0;
            cap_k    <= 2'd0;
            src_ceb  <= 1'b1;
            src_addr <= '0;
            dst_ceb  <= 1'b1;
            dst_wen  <= 1'b1;
            dst_addr <= '0;
            dst_din  <= '0;
            pack     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            pack    <= pack_next;
            cap_vld <= (state == RD);
            cap_k   <= k;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state    <= RD;
                        k        <= 2'd0;
                        grp      <= '0;
                        src_ceb  <= 1'b0;
                        src_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                RD: begin
                    if (k == 2'd3) begin
                        state    <= DRAIN;
                        src_ceb  <= 1'b1;
                        src_addr <= '0;
                    end else begin
                        k        <= k + 2'd1;
                        src_addr <= SRC_AW'({grp, 2'(k + 2'd1)});
                    end
                end
                DRAIN: begin
                    state    <= WR;
                    dst_ceb  <= 1'b0;
                    dst_wen  <= 1'b0;
                    dst_addr <= grp;
                    dst_din  <= pack_next;
                end
                WR: begin
                    dst_ceb  <= 1'b1;
                    dst_wen  <= 1'b1;
                    dst_addr <= '0;
                    dst_din  <= '0;
                    if (last_grp) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= RD;
                        grp      <= grp + DST_AW'(1);
                        k        <= 2'd0;
                        src_ceb  <= 1'b0;
                        src_addr <= SRC_AW'({DST_AW'(grp + DST_AW'(1)), 2'b00});
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    grp   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.SRC_MEM_CEB  = src_ceb;
    assign bus.SRC_MEM_WEN  = 1'b1;
    assign bus.SRC_MEM_ADDR = src_addr;
    assign bus.DST_MEM_CEB  = dst_ceb;
    assign bus.DST_MEM_WEN  = dst_wen;
    assign bus.DST_MEM_ADDR = dst_addr;
    assign bus.DST_MEM_DIN  = dst_din;

`ifdef REQ_SAT_CNT_EN
    // Element was clamped: inf, E>=7 except exact -128, or positive value rounding up to 128
    function automatic logic sat_hit(input logic [31:0] x);
        logic               s;
        logic [7:0]         e;
        logic [22:0]        m;
        logic signed [9:0]  ee;
        logic               hit;
        s   = x[31];
        e   = x[30:23];
        m   = x[22:0];
        ee  = $signed({2'b00, e}) - 10'sd127 + $signed(10'(SCALE_EXP));
        hit = 1'b0;
        if (e == 8'hFF)
            hit = (m == 23'd0);
        else if (e != 8'h00) begin
            if (ee >= 10'sd7)
                hit = !(s && (ee == 10'sd7) && (m == 23'd0));
            else if (ee == 10'sd6)
                hit = !s && (m[22:16] == 7'h7F);
        end
        return hit;
    endfunction

    logic [15:0] sat_cnt;
    logic [2:0]  n_sat;
    logic [16:0] sat_sum;

    always_comb begin
        n_sat = 3'd0;
        for (int j = 0; j < 4; j++)
            n_sat = n_sat + 3'(sat_hit(bus.SRC_MEM_DOUT[32*j +: 32]));
        sat_sum = 17'(sat_cnt) + 17'(n_sat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt <= 16'd0;
        else if (state == IDLE && bus.en)
            sat_cnt <= 16'd0;
        else if (cap_vld)
            sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    assign bus.sat_cnt = sat_cnt;
`endif

endmodule

// File: tb/tb_q_requant_fp32_to_int8.sv
// Directed bench for q_requant_fp32_to_int8: SRAM models, hand-computed INT8 patterns, timing and reset cases.
module tb_q_requant_fp32_to_int8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    q_requant_fp32_to_int8_if #(.SRC_AW(7), .DST_AW(5)) bus ();

    q_requant_fp32_to_int8 #(
        .N_GROUPS(32), .SCALE_EXP(4), .SRC_AW(7), .DST_AW(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    logic [127:0] src_mem [128];
    logic [127:0] dst_mem [32];
    logic         src_req = 1'b0;
    logic [6:0]   src_req_addr = 7'd0;
    int cyc = 0, en_cyc = 0;
    int wr_n = 0, src_n = 0, done_n = 0, first_wr = -1, done_at = -1;
    int wr_addr_err = 0, src_addr_err = 0;
    int checks = 0, failures = 0;

    // Source SRAM: 1-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_req) bus.SRC_MEM_DOUT <= src_mem[src_req_addr];
    end

    // Sample DUT memory ports mid-cycle
    always @(negedge clk) begin
        src_req      = !bus.SRC_MEM_CEB;
        src_req_addr = bus.SRC_MEM_ADDR;
        if (!bus.SRC_MEM_CEB) begin
            if (bus.SRC_MEM_ADDR != 7'(src_n)) src_addr_err++;
            src_n++;
        end
        if (!bus.DST_MEM_CEB && !bus.DST_MEM_WEN) begin
            dst_mem[bus.DST_MEM_ADDR] = bus.DST_MEM_DIN;
            if (wr_n == 0) first_wr = cyc - en_cyc;
            if (bus.DST_MEM_ADDR != 5'(wr_n)) wr_addr_err++;
            wr_n++;
        end
        if (bus.done) begin
            done_n++;
            done_at = cyc - en_cyc;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        bus.en = 1'b1;
        en_cyc = cyc;
        wr_n = 0; src_n = 0; done_n = 0; first_wr = -1; done_at = -1;
        wr_addr_err = 0; src_addr_err = 0;
        @(negedge clk);
        bus.en = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_n == 0 && n < 400) begin
            tick(1);
            n++;
        end
        chk(tag, 128'(done_n > 0), 128'(1));
        tick(3);
    endtask

    task automatic wait_rel(input int target);
        int n;
        n = 0;
        while ((cyc - en_cyc) < target && n < 400) begin
            tick(1);
            n++;
        end
    endtask

    task automatic clear_dst();
        for (int g = 0; g < 32; g++) dst_mem[g] = {4{32'hDEADBEEF}};
    endtask

    // w/64.0 encoded as FP32 (stimulus only)
    function automatic logic [31:0] w64(input int w);
        int p;
        if (w == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 7; i++) if (w[i]) p = i;
        return {1'b0, 8'(p - 6 + 127), 23'((w << (23 - p)) & 32'h7FFFFF)};
    endfunction

    function automatic logic [127:0] w64_exp(input int g);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                r[32*k + 8*j +: 8] = 8'((4*g + k + 2) / 4);
        return r;
    endfunction

    task automatic load_w64();
        for (int w = 0; w < 128; w++) src_mem[w] = {4{w64(w)}};
    endtask

    task automatic load_t1();
        for (int w = 0; w < 128; w++)
            src_mem[w] = {32'hBF000000, 32'h3F000000, 32'hBF800000, 32'h3F800000};
    endtask

    initial begin
        int bad;
        bus.en = 1'b0;
        bus.SRC_MEM_DOUT = '0;
        clear_dst();
        rst = 1'b1;
        tick(3);
        chk("rst_src_ceb",  128'(bus.SRC_MEM_CEB), 128'(1));
        chk("rst_src_wen",  128'(bus.SRC_MEM_WEN), 128'(1));
        chk("rst_dst_ceb",  128'(bus.DST_MEM_CEB), 128'(1));
        chk("rst_dst_wen",  128'(bus.DST_MEM_WEN), 128'(1));
        chk("rst_src_addr", 128'(bus.SRC_MEM_ADDR), 128'(0));
        chk("rst_dst_addr", 128'(bus.DST_MEM_ADDR), 128'(0));
        chk("rst_dst_din",  bus.DST_MEM_DIN, 128'(0));
        chk("rst_busy",     128'(bus.busy), 128'(0));
        chk("rst_done",     128'(bus.done), 128'(0));
`ifdef REQ_SAT_CNT_EN
        chk("rst_sat_cnt",  128'(bus.sat_cnt), 128'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // {1.0,-1.0,0.5,-0.5} everywhere
        load_t1();
        clear_dst();
        start_run();
        tick(10);
        chk("t1_busy_mid", 128'(bus.busy), 128'(1));
        wait_done("t1_done_seen");
        chk("t1_done_at",   128'(done_at), 128'(193));
        chk("t1_first_wr",  128'(first_wr), 128'(6));
        chk("t1_wr_n",      128'(wr_n), 128'(32));
        chk("t1_done_n",    128'(done_n), 128'(1));
        chk("t1_wr_addr",   128'(wr_addr_err), 128'(0));
        chk("t1_src_addr",  128'(src_addr_err), 128'(0));
        chk("t1_src_n",     128'(src_n), 128'(128));
        chk("t1_busy_end",  128'(bus.busy), 128'(0));
        chk("t1_word0",     dst_mem[0],  {4{32'hF808F010}});
        chk("t1_word31",    dst_mem[31], {4{32'hF808F010}});
        bad = 0;
        for (int g = 0; g < 32; g++) if (dst_mem[g] !== {4{32'hF808F010}}) bad++;
        chk("t1_all_words", 128'(bad), 128'(0));
`ifdef REQ_SAT_CNT_EN
        chk("t1_sat_cnt", 128'(bus.sat_cnt), 128'(0));
`endif

        // rounding corners and positive clamp
        for (int w = 0; w < 128; w++) src_mem[w] = '0;
        src_mem[0] = {32'h40FF0000, 32'h3CC00000, 32'hBD000000, 32'h3D000000};
        clear_dst();
        start_run();
        wait_done("t2_done_seen");
        chk("t2_word0", dst_mem[0], {96'h0, 32'h7F00FF01});
        chk("t2_word1", dst_mem[1], 128'h0);
`ifdef REQ_SAT_CNT_EN
        chk("t2_sat_cnt", 128'(bus.sat_cnt), 128'(1));
`endif

        // inf, -inf, NaN, denormal, exact -128
        for (int w = 0; w < 128; w++) src_mem[w] = '0;
        src_mem[5] = {32'h00000001, 32'h7FC00000, 32'hFF800000, 32'h7F800000};
        src_mem[6] = {96'h0, 32'hC1000000};
        clear_dst();
        start_run();
        wait_done("t3_done_seen");
        chk("t3_word1", dst_mem[1], {32'h0, 32'h00000080, 32'h0000807F, 32'h0});
        chk("t3_word0", dst_mem[0], 128'h0);
`ifdef REQ_SAT_CNT_EN
        chk("t3_sat_cnt", 128'(bus.sat_cnt), 128'(2));
`endif

        // distinct value per source word: byte order and address sequence
        load_w64();
        clear_dst();
        start_run();
        wait_done("t4_done_seen");
        for (int g = 0; g < 32; g++) chk($sformatf("t4_word%0d", g), dst_mem[g], w64_exp(g));
        chk("t4_src_addr", 128'(src_addr_err), 128'(0));
        chk("t4_src_n",    128'(src_n), 128'(128));

        // en while busy (grp 5 read phase) is ignored
        clear_dst();
        start_run();
        wait_rel(32);
        bus.en = 1'b1;
        tick(1);
        bus.en = 1'b0;
        chk("t5_busy", 128'(bus.busy), 128'(1));
        wait_done("t5_done_seen");
        tick(20);
        chk("t5_wr_n",   128'(wr_n), 128'(32));
        chk("t5_done_n", 128'(done_n), 128'(1));
        chk("t5_idle",   128'(bus.busy), 128'(0));
        chk("t5_done_at", 128'(done_at), 128'(193));

        // rst during WR of grp 10, then clean restart
        load_t1();
        clear_dst();
        start_run();
        wait_rel(65);
        @(posedge clk);
        #2;
        chk("t6_in_wr",   128'(bus.DST_MEM_CEB), 128'(0));
        rst = 1'b1;
        #1;
        chk("t6_src_ceb", 128'(bus.SRC_MEM_CEB), 128'(1));
        chk("t6_dst_ceb", 128'(bus.DST_MEM_CEB), 128'(1));
        chk("t6_dst_wen", 128'(bus.DST_MEM_WEN), 128'(1));
        chk("t6_busy",    128'(bus.busy), 128'(0));
        chk("t6_din",     bus.DST_MEM_DIN, 128'(0));
        tick(1);
        chk("t6_wr_n", 128'(wr_n), 128'(10));
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        load_w64();
        clear_dst();
        start_run();
        wait_done("t6_done_seen");
        chk("t6_re_wr_n",    128'(wr_n), 128'(32));
        chk("t6_re_wr_addr", 128'(wr_addr_err), 128'(0));
        chk("t6_re_first",   128'(first_wr), 128'(6));
        bad = 0;
        for (int g = 0; g < 32; g++) if (dst_mem[g] !== w64_exp(g)) bad++;
        chk("t6_re_data", 128'(bad), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
